data_sram_ctrl: RTL and testbench

Sequencer between the EX/MEM pipeline boundary and the data SRAM's request/response interface. Accepts one load or store per pipeline slot and forms byte strobes and replicated write data. Drives the SRAM address/data handshake and holds the pipeline via `stallreq` until the access completes. Returns sign- or zero-extended load data to the MEM stage, and flags misaligned accesses and response timeouts.

---
 rtl/data_sram_ctrl_pkg.sv | 44 ++++
 rtl/data_sram_ctrl_if.sv | 22 ++
 rtl/data_sram_ctrl_mem_ld_ext.sv | 28 ++
 rtl/data_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_data_sram_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data SRAM sequencer: size codes, FSM states,
// default timeout and the store-side formatting helpers.
package data_sram_ctrl_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Size code 11 behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] alo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return alo[0];
            SZ_WORD: return alo != 2'b00;
            default: return alo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] alo);
        case (size)
            SZ_BYTE: return 4'b0001 << alo;
            SZ_HALF: return alo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// Data SRAM request/response bus; the controller is the master side.
interface data_sram_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_ctrl_mem_ld_ext.sv
// Load lane select and sign/zero extension of a 32-bit SRAM read word.
module mem_ld_ext
    import data_sram_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: result = {{24{sign & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{sign & lane_h[15]}}, lane_h};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/data_sram_ctrl.sv
// EX/MEM to data SRAM sequencer: issues one load/store, stalls the pipeline
// until the response (or timeout), and returns extended load data.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_mem_valid,
    input  logic                   ex_mem_we,
    input  logic [1:0]             ex_mem_size,
    input  logic                   ex_mem_sign,
    input  logic [31:0]            ex_mem_addr,
    input  logic [31:0]            ex_mem_wdata,
    data_sram_ctrl_if.master       data_sram,
    output logic                   stallreq,
    output logic                   ld_valid,
    output logic [31:0]            ld_result,
    output logic                   adel,
    output logic                   ades,
    output logic                   timeout_err
);
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  alo_q, alo_d;
    logic        err_q, err_d;
    logic [31:0] ld_result_q, ld_result_d;

    logic [31:0] ext_data;
    logic [8:0]  cnt_inc;
    logic        misal, issue, bad, timed_out, req;

    // Input-driven terms are gated by rst so every output drops during reset.
    assign misal     = is_misaligned(ex_mem_size, ex_mem_addr[1:0]);
    assign issue     = rst & (state_q == ST_IDLE) & ex_mem_valid & ~misal;
    assign bad       = rst & (state_q == ST_IDLE) & ex_mem_valid & misal;
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign timed_out = cnt_inc >= TO_LIM;

    mem_ld_ext u_ld_ext (
        .rdata   (data_sram.rdata),
        .size    (size_q),
        .sign    (sign_q),
        .addr_lo (alo_q),
        .result  (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        alo_d       = alo_q;
        err_d       = err_q;
        ld_result_d = ld_result_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    we_d    = ex_mem_we;
                    size_d  = ex_mem_size;
                    sign_d  = ex_mem_sign;
                    alo_d   = ex_mem_addr[1:0];
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = data_sram.addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc[7:0];
                if (data_sram.addr_ok) begin
                    state_d = ST_WAIT;
                end else if (timed_out) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc[7:0];
                if (data_sram.data_ok) begin
                    state_d = ST_RESP;
                    if (!we_q) ld_result_d = ext_data;
                end else if (timed_out) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            alo_q       <= 2'b00;
            err_q       <= 1'b0;
            ld_result_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            alo_q       <= alo_d;
            err_q       <= err_d;
            ld_result_q <= ld_result_d;
        end
    end

    // EX/MEM is held while stalled, so request fields come straight from it.
    assign req             = issue | (state_q == ST_REQ);
    assign data_sram.req   = req;
    assign data_sram.wr    = req & ex_mem_we;
    assign data_sram.size  = req ? ex_mem_size : 2'b00;
    assign data_sram.addr  = req ? ex_mem_addr : 32'd0;
    assign data_sram.wstrb = (req & ex_mem_we) ? wstrb_of(ex_mem_size, ex_mem_addr[1:0]) : 4'b0000;
    assign data_sram.wdata = (req & ex_mem_we) ? wdata_of(ex_mem_size, ex_mem_wdata) : 32'd0;

    assign stallreq    = issue | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign ld_valid    = (state_q == ST_RESP) & ~we_q & ~err_q;
    assign timeout_err = (state_q == ST_RESP) & err_q;
    assign ld_result   = ld_result_q;
    assign adel        = bad & ~ex_mem_we;
    assign ades        = bad & ex_mem_we;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl with a load-result scoreboard.
module tb_data_sram_ctrl;
    logic        clk;
    logic        rst;
    logic        ex_mem_valid;
    logic        ex_mem_we;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_sign;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic        stallreq;
    logic        ld_valid;
    logic [31:0] ld_result;
    logic        adel;
    logic        ades;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_ld;

    data_sram_ctrl_if sram();

    data_sram_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_valid (ex_mem_valid),
        .ex_mem_we    (ex_mem_we),
        .ex_mem_size  (ex_mem_size),
        .ex_mem_sign  (ex_mem_sign),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_wdata (ex_mem_wdata),
        .data_sram    (sram),
        .stallreq     (stallreq),
        .ld_valid     (ld_valid),
        .ld_result    (ld_result),
        .adel         (adel),
        .ades         (ades),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Scoreboard: every load result pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (rst && ld_valid) begin
            if (sb_q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
            else chk("ld_result", ld_result, sb_q.pop_front());
        end
    end

    task automatic drive_op(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
        ex_mem_valid = 1'b1;
        ex_mem_we    = we;
        ex_mem_size  = sz;
        ex_mem_sign  = sg;
        ex_mem_addr  = a;
        ex_mem_wdata = wd;
    endtask

    // Completing access: addr_ok after adly request cycles, data_ok after ddly wait cycles.
    task automatic run_op(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int adly, input int ddly, input logic [3:0] xstrb,
                          input logic [31:0] xwd, input logic [31:0] xld);
        tick();
        drive_op(we, sz, sg, a, wd);
        if (!we) sb_q.push_back(xld);
        for (int c = 0; c <= adly; c++) begin
            if (c > 0) tick();
            sram.addr_ok = (c == adly);
            samp();
            chk({nm, "_req"}, {31'd0, sram.req}, 32'd1);
            chk({nm, "_stall"}, {31'd0, stallreq}, 32'd1);
            chk({nm, "_wr"}, {31'd0, sram.wr}, {31'd0, we});
            chk({nm, "_addr"}, sram.addr, a);
            chk({nm, "_size"}, {30'd0, sram.size}, {30'd0, sz});
            chk({nm, "_wstrb"}, {28'd0, sram.wstrb}, {28'd0, xstrb});
            if (we) chk({nm, "_wdata"}, sram.wdata, xwd);
        end
        tick();
        sram.addr_ok = 1'b0;
        for (int d = 0; d <= ddly; d++) begin
            if (d > 0) tick();
            sram.data_ok = (d == ddly);
            sram.rdata   = rd;
            samp();
            chk({nm, "_wait_req"}, {31'd0, sram.req}, 32'd0);
            chk({nm, "_wait_stall"}, {31'd0, stallreq}, 32'd1);
        end
        tick();
        sram.data_ok = 1'b0;
        ex_mem_valid = 1'b0;
        samp();
        chk({nm, "_resp_stall"}, {31'd0, stallreq}, 32'd0);
        chk({nm, "_resp_ldv"}, {31'd0, ld_valid}, {31'd0, ~we});
        chk({nm, "_resp_to"}, {31'd0, timeout_err}, 32'd0);
        if (we) chk({nm, "_ld_hold"}, ld_result, last_ld);
        else last_ld = xld;
        tick();
        samp();
        chk({nm, "_after_ldv"}, {31'd0, ld_valid}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        sram.addr_ok = 1'b0;
        sram.data_ok = 1'b0;
        sram.rdata   = 32'd0;
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
        last_ld      = 32'd0;
        #3;
        chk("rst_req", {31'd0, sram.req}, 32'd0);
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_ldres", ld_result, 32'd0);
        chk("rst_ldv", {31'd0, ld_valid}, 32'd0);
        chk("rst_to", {31'd0, timeout_err}, 32'd0);
        ex_mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("lb_s", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 0, 0,
               4'b0000, 32'd0, 32'hFFFF_FF80);
        run_op("sh", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 3, 0,
               4'b1100, 32'hBEEF_BEEF, 32'd0);
        run_op("sb", 1'b1, 2'b00, 1'b0, 32'h0000_5003, 32'h1234_565A, 32'd0, 1, 1,
               4'b1000, 32'h5A5A_5A5A, 32'd0);
        run_op("sw", 1'b1, 2'b11, 1'b0, 32'h0000_6004, 32'hCAFE_F00D, 32'd0, 0, 0,
               4'b1111, 32'hCAFE_F00D, 32'd0);
        run_op("lh_s", 1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'd0, 32'h8001_0000, 1, 0,
               4'b0000, 32'd0, 32'hFFFF_8001);
        run_op("lbu", 1'b0, 2'b00, 1'b0, 32'h0000_7001, 32'd0, 32'h0000_F300, 0, 2,
               4'b0000, 32'd0, 32'h0000_00F3);

        // Misaligned load and store: exception pulse, no request.
        tick();
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0);
        samp();
        chk("adel", {31'd0, adel}, 32'd1);
        chk("adel_ades", {31'd0, ades}, 32'd0);
        chk("adel_req", {31'd0, sram.req}, 32'd0);
        chk("adel_stall", {31'd0, stallreq}, 32'd0);
        tick();
        drive_op(1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1111_2222);
        samp();
        chk("ades", {31'd0, ades}, 32'd1);
        chk("ades_adel", {31'd0, adel}, 32'd0);
        chk("ades_req", {31'd0, sram.req}, 32'd0);
        chk("ades_stall", {31'd0, stallreq}, 32'd0);
        tick();
        ex_mem_valid = 1'b0;
        samp();
        chk("mis_clear", {30'd0, adel, ades}, 32'd0);

        // Timeout: addr_ok at issue, data_ok withheld for 4 counted cycles.
        tick();
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'd0);
        sram.addr_ok = 1'b1;
        samp();
        chk("to_issue_req", {31'd0, sram.req}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            sram.addr_ok = 1'b0;
            samp();
            chk("to_wait_stall", {31'd0, stallreq}, 32'd1);
            chk("to_wait_err", {31'd0, timeout_err}, 32'd0);
        end
        tick();
        ex_mem_valid = 1'b0;
        samp();
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_stall", {31'd0, stallreq}, 32'd0);
        tick();
        sram.data_ok = 1'b1;
        sram.rdata   = 32'hDEAD_BEEF;
        samp();
        chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);
        tick();
        sram.data_ok = 1'b0;
        samp();
        chk("to_ld_hold", ld_result, last_ld);
        chk("to_late_ldv", {31'd0, ld_valid}, 32'd0);

        // Reset asserted during WAIT.
        tick();
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'd0);
        sram.addr_ok = 1'b1;
        tick();
        sram.addr_ok = 1'b0;
        samp();
        chk("rw_stall_pre", {31'd0, stallreq}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rw_req", {31'd0, sram.req}, 32'd0);
        chk("rw_stall", {31'd0, stallreq}, 32'd0);
        chk("rw_ldres", ld_result, 32'd0);
        last_ld      = 32'd0;
        ex_mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        sram.data_ok = 1'b1;
        sram.rdata   = 32'h5555_5555;
        samp();
        chk("rw_stale_stall", {31'd0, stallreq}, 32'd0);
        tick();
        sram.data_ok = 1'b0;
        samp();
        chk("rw_stale_hold", ld_result, 32'd0);

        run_op("lhu", 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'd0, 32'h9ABC_0000, 0, 0,
               4'b0000, 32'd0, 32'h0000_9ABC);

        tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
